// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: bubble encoding, next-PC op codes, fetch FSM states and the IF/ID payload.
package if_stage_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JAL    = 2'b10,
    NPC_JALR   = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        vld;
  } ifid_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load beats hold; one edge of latency from d to q.
// Holding (load=0, bubble=0) is how the hazard unit applies backpressure.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '{pc: 32'h0, inst: NOP_INST, vld: 1'b0};
    end else if (bubble) begin
      q <= '{pc: q.pc, inst: NOP_INST, vld: 1'b0};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage: owns the fetch PC, boot/run/halt FSM and IF/ID; imem data reaches IF/ID one edge later.
// Stall holds PC and IF/ID; redirect, flush and halt insert a bubble instead of the fetched word.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_in,
  input  logic [1:0]  npc_op,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid,
  output logic        misalign,
  output logic [31:0] fetch_cnt
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_cnt_q;
  logic         misalign_q;

  logic  active, redirect, do_halt, do_redir, do_norm;
  logic  ifid_load, ifid_bubble;
  ifid_t ifid_d, ifid_q;

  // Halt outranks redirect, which outranks stall; HALTED ignores everything.
  assign active      = (state_q != HALTED);
  assign redirect    = (npc_op != NPC_PLUS4);
  assign do_halt     = active && halt;
  assign do_redir    = active && !halt && redirect;
  assign do_norm     = active && !halt && !redirect && !stall;
  assign ifid_bubble = do_halt || do_redir || (active && !halt && !redirect && flush);
  assign ifid_load   = do_norm;
  assign ifid_d      = '{pc: pc_q, inst: imem_rdata, vld: 1'b1};

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'h0;
    end else begin
      unique case (state_q)
        BOOT:    state_q <= do_halt ? HALTED : RUN;
        RUN:     state_q <= do_halt ? HALTED : RUN;
        default: state_q <= HALTED;
      endcase
      if (do_redir) begin
        pc_q <= {npc_in[31:2], 2'b00};
        if (npc_in[1:0] != 2'b00) misalign_q <= 1'b1;
      end else if (do_norm) begin
        pc_q <= pc_q + 32'd4;
      end
      if (ifid_load && !ifid_bubble) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_inst  = ifid_q.inst;
  assign ifid_valid = ifid_q.vld;
  assign misalign   = misalign_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a reference model pushes expected post-edge state per stimulus step, popped after the edge.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc_in = '0;
  logic [1:0]  npc_op = '0;
  logic        stall = 1'b0, flush = 1'b0, halt = 1'b0;
  logic [31:0] imem_addr, imem_rdata, pc, ifid_pc, ifid_inst, fetch_cnt;
  logic        ifid_valid, misalign;

  if_stage dut (
    .clk(clk), .rst(rst), .npc_in(npc_in), .npc_op(npc_op), .stall(stall), .flush(flush),
    .halt(halt), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc), .ifid_pc(ifid_pc),
    .ifid_inst(ifid_inst), .ifid_valid(ifid_valid), .misalign(misalign), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ MASK;

  typedef struct packed {
    logic [31:0] pc, ipc, inst;
    logic        vld, mis;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] npc;
    logic        st, fl, hl;
  } stim_t;

  exp_t        sb[$];
  logic [31:0] m_pc, m_ipc, m_inst, m_cnt;
  logic        m_vld, m_mis, m_halted;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic exp_t observe();
    return '{pc: pc, ipc: ifid_pc, inst: ifid_inst, vld: ifid_valid, mis: misalign, cnt: fetch_cnt};
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_ipc = '0; m_inst = NOP; m_vld = 1'b0;
    m_mis = 1'b0; m_cnt = '0; m_halted = 1'b0;
    sb.delete();
  endtask

  task automatic bubble();
    m_inst = NOP; m_vld = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, queue its expectation, then step past the edge.
  task automatic drive(input stim_t s);
    npc_op = s.op; npc_in = s.npc; stall = s.st; flush = s.fl; halt = s.hl;
    if (!m_halted) begin
      if (s.hl) begin
        bubble(); m_halted = 1'b1;
      end else if (s.op != 2'b00) begin
        if (s.npc[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = {s.npc[31:2], 2'b00};
        bubble();
      end else if (s.st) begin
        if (s.fl) bubble();
      end else begin
        if (s.fl) bubble();
        else begin
          m_ipc = m_pc; m_inst = m_pc ^ MASK; m_vld = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
    sb.push_back('{pc: m_pc, ipc: m_ipc, inst: m_inst, vld: m_vld, mis: m_mis, cnt: m_cnt});
    @(posedge clk);
    #1;
    npc_op = '0; npc_in = '0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({pc, imem_addr, ifid_pc, ifid_inst, ifid_valid, misalign, fetch_cnt} !==
        {RPC, RPC, 32'h0, NOP, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: got pc=%h addr=%h ipc=%h inst=%h vld=%b mis=%b cnt=%h, want pc=%h inst=%h vld=0 mis=0 cnt=0",
               pc, imem_addr, ifid_pc, ifid_inst, ifid_valid, misalign, fetch_cnt, RPC, NOP);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_boot();
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      drive('{2'b00, 32'h0, 1'b0, 1'b0, 1'b0});
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e || imem_addr !== e.pc) begin
        n_fail++;
        $display("FAIL boot[%0d]: got %h addr=%h, want %h", i, o, imem_addr, e);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t t [5] = '{'{2'b01, 32'h0000_3040, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b10, 32'h0000_3100, 1'b0, 1'b0, 1'b0},
                     '{2'b11, 32'h0000_3200, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0}};
    exp_t e, o;
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got %h, want %h", i, o, e);
      end
    end
  endtask

  task automatic test_stall_flush();
    stim_t t [7] = '{'{2'b01, 32'h0000_300C, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b1, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b1, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b1, 1'b1, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b1, 1'b0}};
    exp_t e, o;
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall_flush[%0d]: got %h, want %h", i, o, e);
      end
    end
  endtask

  task automatic test_misalign();
    stim_t t [4] = '{'{2'b11, 32'h0000_2003, 1'b1, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b01, 32'h0000_2100, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0}};
    exp_t e, o;
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL misalign[%0d]: got %h, want %h", i, o, e);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t [4] = '{'{2'b10, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0}};
    exp_t e, o;
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h, want %h", i, o, e);
      end
    end
  endtask

  task automatic test_halt();
    stim_t t [6] = '{'{2'b01, 32'h0000_3020, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b1},
                     '{2'b11, 32'h0000_4001, 1'b0, 1'b1, 1'b0},
                     '{2'b00, 32'h0, 1'b1, 1'b1, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0},
                     '{2'b00, 32'h0, 1'b0, 1'b0, 1'b0}};
    exp_t e, o;
    foreach (t[i]) begin
      drive(t[i]);
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL halt[%0d]: got %h, want %h", i, o, e);
      end
    end
    // Reset pulse between edges must take effect without a clock.
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({pc, ifid_pc, ifid_inst, ifid_valid, misalign, fetch_cnt} !==
        {RPC, 32'h0, NOP, 1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h ipc=%h inst=%h vld=%b mis=%b cnt=%h, want pc=%h ipc=0 inst=%h vld=0 mis=0 cnt=0",
               pc, ifid_pc, ifid_inst, ifid_valid, misalign, fetch_cnt, RPC, NOP);
    end
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    for (int i = 0; i < 3; i++) begin
      drive('{2'b00, 32'h0, 1'b0, 1'b0, 1'b0});
      e = sb.pop_front(); o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL after_reset[%0d]: got %h, want %h", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_redirect();
    test_stall_flush();
    test_misalign();
    test_wrap();
    test_halt();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
